// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator.
// Holds the fetch FSM state type, the next-PC source select and the
// default exception vector. The optional return-address stack is enabled
// by defining PC_RAS_EN.
package pc_pkg;

   // Fetch FSM: BOOT for one cycle after reset, RUN normally, HOLD while a
   // redirect target is parked waiting for the fetch to be accepted.
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } pc_state_e;

   // Sequential fetch increment (one 32-bit instruction).
   localparam int unsigned PC_INC = 4;

   // Default exception entry address; the top truncates it to WIDTH.
   localparam logic [31:0] PC_EXC_VEC = 32'h0000_0180;

   // Source of the next PC, listed from "no change" up to the
   // highest-priority events.
   typedef enum logic [2:0] {
      SEL_KEEP = 3'd0,  // no advance, PC holds
      SEL_SEQ  = 3'd1,  // PC + 4
      SEL_TGT  = 3'd2,  // jump/branch target taken directly
      SEL_PARK = 3'd3,  // jump/branch target parked in pend_addr
      SEL_PEND = 3'd4,  // parked target released
      SEL_RAS  = 3'd5,  // return address popped from the stack
      SEL_EXC  = 3'd6,  // exception vector
      SEL_ERET = 3'd7   // return from exception
   } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. A push when full overwrites the
// oldest entry; a pop on an empty stack is ignored. A simultaneous push
// and pop replaces the top entry. Only instantiated when PC_RAS_EN is
// defined.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] top,
   output logic             empty
);

   localparam int unsigned AW = $clog2(RAS_DEPTH);

   logic [WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [AW-1:0]    wr_ptr_q;   // next slot to write
   logic [AW-1:0]    top_idx;    // most recently written slot
   logic [AW:0]      cnt_q;      // live entries, saturates at RAS_DEPTH

   assign top_idx = wr_ptr_q - 1'b1;
   assign top     = mem_q[top_idx];
   assign empty   = (cnt_q == '0);

   // Stack pointer, occupancy and storage update.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      end else if (push && pop && !empty) begin
         mem_q[top_idx] <= push_data;
      end else if (push) begin
         mem_q[wr_ptr_q] <= push_data;
         wr_ptr_q        <= wr_ptr_q + 1'b1;
         if (cnt_q != (AW+1)'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
      end else if (pop && !empty) begin
         wr_ptr_q <= wr_ptr_q - 1'b1;
         cnt_q    <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Computes the next fetch address from sequential advance, jump/branch
// redirects, exception entry (with EPC capture) and ERET. A redirect that
// arrives while fetch is blocked is parked and released on the next
// accepted fetch. Define PC_RAS_EN to add a return-address stack
// (pc_ras) serving call/ret; without it call/ret are ignored.
//
// Handshake: PC is a fetch request whenever fetch_valid is high. The
// request is accepted (adv) on a rising edge where fetch_valid and
// fetch_ready are high and stall is low; only then does PC advance or take
// a jump/branch target. exc and eret update PC on the next edge
// regardless of the handshake.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
   parameter int unsigned      RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             exc,
   input  logic             eret,
   input  logic             call,
   input  logic             ret,
   input  logic             fetch_ready,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] epc,
   output logic             ras_empty,
   output pc_state_e        state_dbg
);

   // Instruction addresses are word aligned: bits [1:0] always cleared.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   pc_state_e        state_q, state_d;
   pc_sel_e          sel;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             fv_q;
   logic             adv;
   logic             rdr_new;
   logic [WIDTH-1:0] rdr_tgt;
   logic [WIDTH-1:0] pc_inc;
   logic             ras_hit;
   logic [WIDTH-1:0] ras_top;

   assign adv     = fv_q & fetch_ready & ~stall;
   assign rdr_new = jmp | br_taken;
   assign rdr_tgt = (jmp ? jmp_target : br_target) & ALIGN_MASK;
   assign pc_inc  = pc_q + WIDTH'(PC_INC);

`ifdef PC_RAS_EN
   logic             ras_push;
   logic             ras_pop;
   logic             ras_empty_w;
   logic [WIDTH-1:0] ras_top_w;

   // A call pushes its return address whenever the fetch is accepted,
   // except in the cycle an exception or ERET takes over the PC.
   assign ras_push = call & adv & ~exc & ~eret;
   assign ras_pop  = (sel == SEL_RAS);
   assign ras_hit  = ret & ~ras_empty_w;
   assign ras_top  = ras_top_w & ALIGN_MASK;
   assign ras_empty = ras_empty_w;

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .Reset     (Reset),
      .push      (ras_push),
      .push_data (pc_inc),
      .pop       (ras_pop),
      .top       (ras_top_w),
      .empty     (ras_empty_w)
   );
`else
   logic unused_ras;

   assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
   assign ras_hit    = 1'b0;
   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
`endif

   // Pick the next-PC source by priority: exc > eret > jmp/br > parked
   // target > ret > PC+4.
   always_comb begin
      sel = SEL_KEEP;
      if (exc)          sel = SEL_EXC;
      else if (eret)    sel = SEL_ERET;
      else if (rdr_new) sel = adv ? SEL_TGT : SEL_PARK;
      else if (adv) begin
         if (state_q == HOLD) sel = SEL_PEND;
         else if (ras_hit)    sel = SEL_RAS;
         else                 sel = SEL_SEQ;
      end
   end

   // Next state, next PC, EPC capture and parked target.
   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      pend_d  = pend_q;
      state_d = (state_q == BOOT) ? RUN : state_q;
      case (sel)
         SEL_EXC: begin
            pc_d    = EXC_VEC & ALIGN_MASK;
            epc_d   = pc_q;
            state_d = RUN;
         end
         SEL_ERET: begin
            pc_d    = epc_q;
            state_d = RUN;
         end
         SEL_TGT: begin
            pc_d    = rdr_tgt;
            state_d = RUN;
         end
         SEL_PARK: begin
            pend_d  = rdr_tgt;
            state_d = HOLD;
         end
         SEL_PEND: begin
            pc_d    = pend_q;
            state_d = RUN;
         end
         SEL_RAS: begin
            pc_d    = ras_top;
            state_d = RUN;
         end
         SEL_SEQ:  pc_d = pc_inc;
         default:  ;
      endcase
   end

   // State and PC registers; fetch_valid is its own flop so it is glitch free.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         pend_q  <= '0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         pend_q  <= pend_d;
         fv_q    <= (state_d != BOOT);
      end
   end

   assign fetch_valid = fv_q;
   assign PC          = pc_q;
   assign epc         = epc_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a behavioural model of pc_gen.
`timescale 1ns/1ps
module tb_pc_gen;
   import pc_pkg::*;

   localparam int         W     = 32;
   localparam logic [W-1:0] RST_V = 32'h0000_0000;
   localparam logic [W-1:0] EXC_V = 32'h0000_0180;
   localparam int         DEPTH = 4;
   localparam logic [W-1:0] AMASK = 32'hFFFF_FFFC;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 clk = ~clk;

   logic           stall, br_taken, jmp, exc, eret, call, ret, fetch_ready;
   logic [W-1:0]   br_target, jmp_target;
   logic           fetch_valid, ras_empty;
   logic [W-1:0]   PC, epc;
   pc_state_e      state_dbg;

   pc_gen #(
      .WIDTH     (W),
      .RESET_VEC (RST_V),
      .EXC_VEC   (EXC_V),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jmp         (jmp),
      .jmp_target  (jmp_target),
      .exc         (exc),
      .eret        (eret),
      .call        (call),
      .ret         (ret),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .PC          (PC),
      .epc         (epc),
      .ras_empty   (ras_empty),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoring ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_pc   = RST_V;
   logic [W-1:0] m_epc  = '0;
   logic [W-1:0] m_pend = '0;
   bit           m_valid = 1'b0;
   bit           m_hold  = 1'b0;
   logic [W-1:0] m_stack[$];
   bit           mv_adv;
   logic [W-1:0] mv_tgt;
`ifdef PC_RAS_EN
   logic [W-1:0] mv_ret_addr;
`endif

   always @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         m_pc = RST_V; m_epc = '0; m_pend = '0;
         m_valid = 1'b0; m_hold = 1'b0;
         m_stack.delete();
      end else begin
         mv_adv = m_valid && fetch_ready && !stall;
`ifdef PC_RAS_EN
         mv_ret_addr = m_pc + 4;
`endif
         if (exc) begin
            m_epc  = m_pc;
            m_pc   = EXC_V & AMASK;
            m_hold = 1'b0;
         end else if (eret) begin
            m_pc   = m_epc;
            m_hold = 1'b0;
         end else if (jmp || br_taken) begin
            mv_tgt = (jmp ? jmp_target : br_target) & AMASK;
            if (mv_adv) begin
               m_pc   = mv_tgt;
               m_hold = 1'b0;
            end else begin
               m_pend = mv_tgt;
               m_hold = 1'b1;
            end
         end else if (mv_adv) begin
            if (m_hold) begin
               m_pc   = m_pend;
               m_hold = 1'b0;
            end
`ifdef PC_RAS_EN
            else if (ret && m_stack.size() > 0) begin
               m_pc = m_stack.pop_back();
            end
`endif
            else begin
               m_pc = m_pc + 4;
            end
         end
`ifdef PC_RAS_EN
         if (call && mv_adv && !exc && !eret) begin
            m_stack.push_back(mv_ret_addr);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
         end
`endif
         m_valid = 1'b1;
      end
   end

   function automatic pc_state_e exp_state();
      if (!m_valid) return BOOT;
      if (m_hold)   return HOLD;
      return RUN;
   endfunction

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("fetch_valid", W'(fetch_valid), W'(m_valid));
      chk("pc", PC, m_pc);
      chk("epc", epc, m_epc);
      chk("ras_empty", W'(ras_empty), W'(m_stack.size() == 0));
      chk("state", W'(state_dbg), W'(exp_state()));
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; exc = 1'b0; eret = 1'b0;
      call = 1'b0; ret = 1'b0; br_target = '0; jmp_target = '0;
   endtask

   // Jump with the fetch accepted; PC equals addr at the next negedge.
   task automatic go_to(input logic [W-1:0] addr);
      jmp = 1'b1; jmp_target = addr;
      @(negedge clk);
      jmp = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] ret_exp [4];
      ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;

      idle();
      fetch_ready = 1'b1;
      #1 Reset = 1'b0;
      #2;
      chk("rst_pc", PC, RST_V);
      chk("rst_fv", W'(fetch_valid), 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_ras_empty", W'(ras_empty), 32'd1);
      chk("rst_state", W'(state_dbg), W'(BOOT));

      // Boot: one cycle without fetch_valid, then 0,4,8,12.
      @(negedge clk);
      #2 Reset = 1'b1;
      #1 chk("boot_fv", W'(fetch_valid), 32'd0);
      @(negedge clk); chk("seq0", PC, 32'h0); chk("seq0_fv", W'(fetch_valid), 32'd1);
      @(negedge clk); chk("seq1", PC, 32'h4);
      @(negedge clk); chk("seq2", PC, 32'h8);
      @(negedge clk); chk("seq3", PC, 32'hC);

      // Branch while fetch is blocked: parked, released on the first accept.
      fetch_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_1003;
      @(negedge clk);
      br_taken = 1'b0;
      chk("hold_pc", PC, 32'hC);
      chk("hold_state", W'(state_dbg), W'(HOLD));
      chk("model_hold_pc", m_pc, 32'hC);
      @(negedge clk);
      chk("hold_pc2", PC, 32'hC);
      fetch_ready = 1'b1;
      @(negedge clk);
      chk("release_pc", PC, 32'h1000);
      chk("release_state", W'(state_dbg), W'(RUN));
      chk("model_release_pc", m_pc, 32'h1000);

      // Exception under stall, then ERET.
      go_to(32'h40);
      chk("goto40", PC, 32'h40);
      stall = 1'b1; exc = 1'b1;
      @(negedge clk);
      exc = 1'b0;
      chk("exc_pc", PC, 32'h180);
      chk("exc_epc", epc, 32'h40);
      eret = 1'b1;
      @(negedge clk);
      eret = 1'b0; stall = 1'b0;
      chk("eret_pc", PC, 32'h40);

      // exc and eret together: exc wins.
      go_to(32'h200);
      exc = 1'b1; eret = 1'b1;
      @(negedge clk);
      exc = 1'b0; eret = 1'b0;
      chk("exc_eret_pc", PC, 32'h180);
      chk("exc_eret_epc", epc, 32'h200);
      chk("model_exc_eret_epc", m_epc, 32'h200);

      // Five calls, then five returns.
      for (int i = 1; i <= 5; i++) begin
         go_to(W'(i * 16));
         call = 1'b1;
         @(negedge clk);
         call = 1'b0;
      end
      chk("after_calls_pc", PC, 32'h54);
`ifdef PC_RAS_EN
      chk("after_calls_ras_empty", W'(ras_empty), 32'd0);
`endif
      ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
`ifdef PC_RAS_EN
         chk("ret_pc", PC, ret_exp[i]);
`endif
      end
`ifdef PC_RAS_EN
      chk("ret_drained_empty", W'(ras_empty), 32'd1);
`endif
      @(negedge clk);
      ret = 1'b0;
`ifdef PC_RAS_EN
      chk("ret_empty_fallthrough", PC, 32'h28);
`else
      chk("ret_ignored_pc", PC, 32'h68);
`endif
      chk("ras_empty_final", W'(ras_empty), 32'd1);

      // Wrap-around at the top of the address space.
      go_to(32'hFFFF_FFFC);
      chk("wrap_pre", PC, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_pc", PC, 32'h0);

      // Reset in the middle of HOLD drops the parked target.
      fetch_ready = 1'b0; jmp = 1'b1; jmp_target = 32'h3000;
      @(negedge clk);
      jmp = 1'b0;
      chk("pre_rst_state", W'(state_dbg), W'(HOLD));
      #2 Reset = 1'b0;
      #1;
      chk("midrst_pc", PC, RST_V);
      chk("midrst_fv", W'(fetch_valid), 32'd0);
      chk("midrst_state", W'(state_dbg), W'(BOOT));
      fetch_ready = 1'b1;
      @(negedge clk);
      #2 Reset = 1'b1;
      @(negedge clk); chk("postrst_pc0", PC, 32'h0);
      @(negedge clk); chk("postrst_pc1", PC, 32'h4);

      // Randomised traffic against the model.
      repeat (3000) begin
         @(negedge clk);
         stall       = ($urandom_range(0, 99) < 20);
         fetch_ready = ($urandom_range(0, 99) < 75);
         exc         = ($urandom_range(0, 99) < 3);
         eret        = ($urandom_range(0, 99) < 3);
         jmp         = ($urandom_range(0, 99) < 10);
         br_taken    = ($urandom_range(0, 99) < 10);
         jmp_target  = $urandom;
         br_target   = $urandom;
         call        = ($urandom_range(0, 99) < 12);
         ret         = !call && ($urandom_range(0, 99) < 15);
      end
      @(negedge clk);
      idle();
      @(negedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS core fetch stage; the successor to the bare PC register. It holds the PC and computes the next fetch address:
- sequential +4, branch/jump redirect, exception vectoring with EPC capture, ERET return;
- optional return-address stack.

It handshakes with instruction memory and latches a redirect that arrives while fetch is blocked, so no redirect is ever lost.

## Interface
- WIDTH, 32, address width (≥ 8)
- RESET_VEC, 0, PC value after reset
- EXC_VEC, 32'h0000_0180, exception entry address (truncated to WIDTH)
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥ 2)

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hold; blocks sequential advance
- br_taken  in  1  branch resolved taken this cycle
- br_target  in  WIDTH  branch destination
- jmp  in  1  J/JAL/JR this cycle
- jmp_target  in  WIDTH  jump destination
- exc  in  1  exception request
- eret  in  1  return from exception
- call  in  1  current fetch is a call (JAL/JALR)
- ret  in  1  current fetch is JR $ra
- fetch_ready  in  1  instruction memory accepts address
- fetch_valid  out  1  PC is a valid fetch request
- PC  out  WIDTH  current fetch address
- epc  out  WIDTH  saved exception PC
- ras_empty  out  1  stack holds no entries

## Operation
- States:
  - BOOT: one cycle after reset release, fetch_valid=0.
  - RUN: fetch_valid=1.
  - HOLD: redirect pending, fetch_valid=1.
- Advance condition: adv = fetch_valid & fetch_ready & ~stall.
- Redirect priority: exc > eret > jmp > br_taken > ret (RAS) > PC+4.
- exc and eret act immediately regardless of stall/fetch_ready.
  - exc: PC←EXC_VEC, epc←PC.
  - eret: PC←epc.
  - Either one clears any pending redirect.
- jmp/br_taken with adv: PC←target next edge.
- jmp/br_taken without adv: target stored in pend_addr, enter HOLD.
  - In HOLD, the first adv loads PC←pend_addr and returns to RUN.
  - A new jmp/br in HOLD overwrites pend_addr.
- No redirect, adv: PC←PC+4, modulo 2^WIDTH (0xFFFF_FFFC→0x0).
- No adv: PC holds.
- All targets have bits [1:0] forced to 0.
- exc and eret in the same cycle: exc wins; epc←PC.

## Timing
- Reset (async, Reset=0):
  - PC=RESET_VEC, epc=0, state BOOT.
  - fetch_valid=0, ras_empty=1, pending cleared.
- BOOT→RUN on the first clk edge after reset release.
- Redirect latency: 1 cycle from input to PC when adv or exc/eret; otherwise held until the first adv.
- fetch_valid and PC change only on rising clk; both are purely registered.
- Reset asserted mid-HOLD discards the pending target.

## Configuration
- PC_RAS_EN defined:
  - call on adv pushes PC+4, circular; when full, the oldest entry is overwritten.
  - ret on adv with no higher-priority redirect pops; PC←top.
  - ret with an empty stack falls through to PC+4.
  - exc leaves the stack intact.
- PC_RAS_EN undefined:
  - call and ret are ignored; ras_empty tied to 1.
  - No stack storage is generated.

## Structure
- pc_pkg holds:
  - state typedef {BOOT, RUN, HOLD};
  - PC_INC=4;
  - the default EXC_VEC constant;
  - the redirect-select enum.
- Sub-module pc_ras (parameters WIDTH, RAS_DEPTH; push/pop/top/empty), instantiated only under PC_RAS_EN.

## Test plan
- Reset release, fetch_ready=1, no events -> fetch_valid=0 for one cycle, then PC=0,4,8,12 on consecutive cycles.
- br_taken=1, br_target=0x0000_1003 while fetch_ready=0 -> PC holds, state HOLD; fetch_ready=1 two cycles later -> PC=0x0000_1000 next edge.
- PC=0x40, stall=1, exc=1 -> next cycle PC=0x180, epc=0x40; eret=1 -> PC=0x40.
- exc=1 and eret=1 together at PC=0x200 -> PC=0x180, epc=0x200.
- PC_RAS_EN, RAS_DEPTH=4:
  - five calls at PC 0x10/0x20/0x30/0x40/0x50, then four rets -> PC=0x54,0x44,0x34,0x24;
  - a fifth ret -> ras_empty=1 and PC+4.
- PC=0xFFFF_FFFC, adv -> PC=0x0; Reset pulsed low mid-HOLD -> PC=RESET_VEC immediately, pending target dropped.
